multiplicacao: RTL and testbench

- Sequential signed multiplier for the MIPS datapath's `mult` instruction.
- Uses radix-2 Booth, one iteration per falling clock edge, and writes the 64-bit product into Hi/Lo.
- The control unit starts it with the `multIn` handshake and waits for `multOut`, the same start/done handshake used by the divider unit.

---
 rtl/mult_pkg.sv | 12 +
 rtl/booth_passo.sv | 33 +++
 rtl/multiplicacao.sv | 111 +++++++++++
 tb/tb_multiplicacao.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier: operand width,
// FSM state encoding and the Booth recoding constants.
package mult_pkg;

  localparam int MULT_N = 32;

  typedef enum logic {IDLE, RUN} mult_state_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_passo.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A,
// followed by an arithmetic shift right of {A, Q, Q_1}.
module booth_passo
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] q,
  input  logic         q_1,
  input  logic [N:0]   m,
  output logic [N:0]   a_next,
  output logic [N-1:0] q_next,
  output logic         q_1_next
);

  logic [N:0] sum;

  always_comb begin
    sum = a;
    unique case ({q[0], q_1})
      BOOTH_ADD: sum = a + m;
      BOOTH_SUB: sum = a - m;
      default:   sum = a;
    endcase
  end

  // A is one bit wider than the operands, so its MSB is the true sign.
  assign a_next   = {sum[N], sum[N:1]};
  assign q_next   = {sum[0], q[N-1:1]};
  assign q_1_next = q[0];

endmodule

// File: rtl/multiplicacao.sv
// Sequential signed multiplier (radix-2 Booth, one step per falling edge)
// with a multIn/multOut start/done handshake and registered Hi/Lo outputs.
module multiplicacao
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] Multiplicando,
  input  logic [N-1:0] Multiplicador,
  input  logic         multIn,
  output logic         multOut,
  output logic [N-1:0] Hi,
  output logic [N-1:0] Lo
);

  localparam int CW = $clog2(N) + 1;

  mult_state_t   state_reg, state_next;
  logic [N:0]    a_reg, a_next;
  logic [N-1:0]  q_reg, q_next;
  logic          q_1_reg, q_1_next;
  logic [N:0]    m_reg, m_next;
  logic [CW-1:0] cont_reg, cont_next;
  logic [N-1:0]  hi_reg, hi_next;
  logic [N-1:0]  lo_reg, lo_next;
  logic          done_reg, done_next;

  logic [N:0]    a_step;
  logic [N-1:0]  q_step;
  logic          q_1_step;

  booth_passo #(.N(N)) u_passo (
    .a        (a_reg),
    .q        (q_reg),
    .q_1      (q_1_reg),
    .m        (m_reg),
    .a_next   (a_step),
    .q_next   (q_step),
    .q_1_next (q_1_step)
  );

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      q_reg     <= '0;
      q_1_reg   <= 1'b0;
      m_reg     <= '0;
      cont_reg  <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      q_reg     <= q_next;
      q_1_reg   <= q_1_next;
      m_reg     <= m_next;
      cont_reg  <= cont_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    q_next     = q_reg;
    q_1_next   = q_1_reg;
    m_next     = m_reg;
    cont_next  = cont_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    done_next  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (multIn) begin
          a_next     = '0;
          q_next     = Multiplicador;
          q_1_next   = 1'b0;
          m_next     = {Multiplicando[N-1], Multiplicando};
          cont_next  = CW'(N);
          state_next = RUN;
        end
      end
      RUN: begin
        a_next    = a_step;
        q_next    = q_step;
        q_1_next  = q_1_step;
        cont_next = cont_reg - 1'b1;
        // Last step: publish the product computed on this very edge.
        if (cont_next == '0) begin
          hi_next    = a_step[N-1:0];
          lo_next    = q_step;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign multOut = done_reg;
  assign Hi      = hi_reg;
  assign Lo      = lo_reg;

endmodule

// File: tb/tb_multiplicacao.sv
// Self-checking bench for multiplicacao: vector table, back-to-back,
// reset abort and random signed pairs against a 64-bit reference product.
module tb_multiplicacao;

  localparam int N = 32;

  logic          clock;
  logic          reset;
  logic [N-1:0]  multiplicando;
  logic [N-1:0]  multiplicador;
  logic          mult_in;
  logic          mult_out;
  logic [N-1:0]  hi;
  logic [N-1:0]  lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0] prev_hi, prev_lo;

  typedef struct {
    logic [N-1:0] m;
    logic [N-1:0] q;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
  } vec_t;

  vec_t vecs[8];

  multiplicacao #(.N(N)) dut (
    .clock         (clock),
    .reset         (reset),
    .Multiplicando (multiplicando),
    .Multiplicador (multiplicador),
    .multIn        (mult_in),
    .multOut       (mult_out),
    .Hi            (hi),
    .Lo            (lo)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete operation; expects done exactly N falling edges after start.
  task automatic run_op(input string name, input logic [N-1:0] m, input logic [N-1:0] q,
                        input logic [N-1:0] e_hi, input logic [N-1:0] e_lo);
    int done_at;
    int pulses;
    logic [N-1:0] got_hi, got_lo;
    done_at = 0;
    pulses  = 0;
    got_hi  = '0;
    got_lo  = '0;
    @(posedge clock);
    multiplicando = m;
    multiplicador = q;
    mult_in       = 1'b1;
    @(negedge clock);
    #1;
    check({name, "_start_no_done"}, {63'd0, mult_out}, 64'd0);
    mult_in       = 1'b0;
    multiplicando = ~m;
    multiplicador = ~q;
    for (int i = 1; i <= N + 1; i++) begin
      @(negedge clock);
      #1;
      if (i == N - 1)
        check({name, "_hold_prev"}, {hi, lo}, {prev_hi, prev_lo});
      if (mult_out) begin
        pulses++;
        if (done_at == 0) begin
          done_at = i;
          got_hi  = hi;
          got_lo  = lo;
        end
      end
    end
    check({name, "_latency"}, 64'(done_at), 64'(N));
    check({name, "_pulses"}, 64'(pulses), 64'd1);
    check({name, "_hilo"}, {got_hi, got_lo}, {e_hi, e_lo});
    $display("op %s: %h x %h -> Hi=%h Lo=%h done@%0d", name, m, q, got_hi, got_lo, done_at);
    prev_hi = e_hi;
    prev_lo = e_lo;
  endtask

  initial begin
    logic [N-1:0] pool[6];
    logic [N-1:0] rm, rq;
    logic signed [63:0] ref_p;
    bit d1, d2;
    int pulses;

    vecs[0] = '{32'd7,        32'd6,        32'h00000000, 32'h0000002A};
    vecs[1] = '{32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[4] = '{32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[6] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000};
    vecs[7] = '{32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000};
    pool = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h12345678};

    reset         = 1'b0;
    mult_in       = 1'b0;
    multiplicando = '0;
    multiplicador = '0;
    prev_hi       = '0;
    prev_lo       = '0;
    #2;
    check("reset_state", {31'd0, mult_out, hi, lo}, 64'd0);
    repeat (2) @(posedge clock);
    reset = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].q, vecs[i].hi, vecs[i].lo);

    // multIn held high through RUN with changing operands: second op chains.
    @(posedge clock);
    multiplicando = 32'd7;
    multiplicador = 32'd6;
    mult_in       = 1'b1;
    @(negedge clock);
    #1;
    multiplicando = 32'd2;
    multiplicador = 32'd2;
    d1 = 0;
    d2 = 0;
    pulses = 0;
    for (int i = 1; i <= 2 * N + 2; i++) begin
      @(negedge clock);
      #1;
      if (i == N + 1) begin
        check("b2b_fall", {63'd0, mult_out}, 64'd0);
        mult_in = 1'b0;
      end
      if (mult_out) begin
        pulses++;
        if (i == N) begin
          d1 = 1;
          check("b2b_first", {hi, lo}, {32'd0, 32'd42});
        end else if (i == 2 * N + 1) begin
          d2 = 1;
          check("b2b_second", {hi, lo}, {32'd0, 32'd4});
        end else begin
          check("b2b_stray_pulse_edge", 64'(i), 64'd0);
        end
      end
    end
    check("b2b_done_flags", {62'd0, d1, d2}, 64'd3);
    check("b2b_pulses", 64'(pulses), 64'd2);
    $display("op b2b: 7x6 then 2x2, pulses=%0d", pulses);
    prev_hi = 32'd0;
    prev_lo = 32'd4;

    // Abort after ten Booth steps with an asynchronous reset between edges.
    @(posedge clock);
    multiplicando = 32'h12345678;
    multiplicador = 32'h10;
    mult_in       = 1'b1;
    @(negedge clock);
    #1;
    mult_in = 1'b0;
    repeat (10) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("abort_immediate", {31'd0, mult_out, hi, lo}, 64'd0);
    pulses = 0;
    repeat (3) begin
      @(negedge clock);
      #1;
      if (mult_out) pulses++;
    end
    @(posedge clock);
    reset = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clock);
      #1;
      if (mult_out) pulses++;
    end
    check("abort_no_pulse", 64'(pulses), 64'd0);
    check("abort_held_zero", {hi, lo}, 64'd0);
    $display("op abort: reset mid-run, pulses=%0d", pulses);
    prev_hi = '0;
    prev_lo = '0;
    run_op("post_reset", 32'd3, 32'd3, 32'd0, 32'd9);

    for (int i = 0; i < 12; i++) begin
      rm = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      rq = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      ref_p = $signed({{32{rm[31]}}, rm}) * $signed({{32{rq[31]}}, rq});
      run_op($sformatf("rand%0d", i), rm, rq, ref_p[63:32], ref_p[31:0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
